// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg
// Shared definitions for the multi-cycle shift/rotate unit:
//   - operation encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROL)
//   - FSM state type (ST_IDLE, ST_SHIFT, ST_DONE)
//   - default datapath width
// Optional feature macro used by the importing files: SHIFT_ROTATE_EN.
package alu_shift_pkg;

   localparam int DEF_WIDTH = 8;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step
// Combinational single-position step of the shift/rotate unit.
// Ports:
//   op        in   2      operation (OP_SLL / OP_SRL / OP_SRA / OP_ROL)
//   dout      in   WIDTH  current working value
//   next_dout out  WIDTH  value after one step
//   next_carry out 1      bit shifted or rotated out by this step
// Configuration: SHIFT_ROTATE_EN defined builds the rotate path; when it is
// undefined op 11 falls through to the SLL behaviour.
module shift_step
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] next_dout,
   output logic             next_carry
);

   always_comb begin
      // SLL is the default so any op without a dedicated path shifts left.
      next_dout  = {dout[WIDTH-2:0], 1'b0};
      next_carry = dout[WIDTH-1];
      case (op)
         OP_SRL: begin
            next_dout  = {1'b0, dout[WIDTH-1:1]};
            next_carry = dout[0];
         end
         OP_SRA: begin
            next_dout  = {dout[WIDTH-1], dout[WIDTH-1:1]};
            next_carry = dout[0];
         end
`ifdef SHIFT_ROTATE_EN
         OP_ROL: begin
            next_dout  = {dout[WIDTH-2:0], dout[WIDTH-1]};
            next_carry = dout[WIDTH-1];
         end
`endif
         default: begin
            next_dout  = {dout[WIDTH-2:0], 1'b0};
            next_carry = dout[WIDTH-1];
         end
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle shift/rotate unit, one bit position per clock. Accepts an
// operand/op/amount on a start strobe, shifts amt times, then pulses done
// for one cycle with the result held on dout/carry.
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous active-low reset
//   start  in   1      request strobe (accepted in IDLE or DONE)
//   op     in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   amt    in   AMT_W  shift amount
//   din    in   WIDTH  operand
//   dout   out  WIDTH  working/result register
//   busy   out  1      high while shifting
//   done   out  1      one-cycle completion pulse
//   carry  out  1      last bit shifted/rotated out (0 when amt is 0)
// Configuration: SHIFT_ROTATE_EN (see shift_step) enables ROL for op 11.
module shift_sequencer
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done,
   output logic             carry
);

   state_t           state;
   logic [AMT_W-1:0] cnt;
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] step_dout;
   logic             step_carry;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op         (op_reg),
      .dout       (dout),
      .next_dout  (step_dout),
      .next_carry (step_carry)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= ST_IDLE;
         dout   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         op_reg <= OP_SLL;
      end else begin
         case (state)
            // DONE accepts a new request exactly like IDLE so operations
            // can be issued back to back without an idle bubble.
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  dout   <= din;
                  cnt    <= amt;
                  op_reg <= op;
                  carry  <= 1'b0;
                  state  <= (amt == '0) ? ST_DONE : ST_SHIFT;
               end else begin
                  state  <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               dout  <= step_dout;
               carry <= step_carry;
               cnt   <= cnt - 1'b1;
               // cnt counts remaining steps including this one.
               if (cnt == AMT_W'(1)) begin
                  state <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
// Table-driven check of shift_sequencer plus hand-written sequences for
// back-to-back issue and mid-operation reset. Expected ROL results follow
// SHIFT_ROTATE_EN the same way the design does.
module tb_shift_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [2:0] amt;
   logic [7:0] din;
   logic [7:0] dout;
   logic       busy;
   logic       done;
   logic       carry;

   int total = 0;
   int bad   = 0;

   shift_sequencer #(
      .WIDTH (8),
      .AMT_W (3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .amt   (amt),
      .din   (din),
      .dout  (dout),
      .busy  (busy),
      .done  (done),
      .carry (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [2:0] amt;
      logic [7:0] din;
      logic [7:0] exp_dout;
      logic       exp_carry;
      int         glitch;   // cycle index for an extra start during SHIFT, 0 = none
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; drives one start pulse and waits for
   // done (bounded). Returns with the bench at the falling edge where done=1.
   task automatic launch(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d,
                         input int glitch, output int cycles, output int busy_cnt,
                         output bit seen);
      start = 1'b1;
      op    = o;
      amt   = a;
      din   = d;
      @(negedge clk);
      start    = 1'b0;
      cycles   = 1;
      busy_cnt = 0;
      seen     = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         start = (glitch != 0 && cycles == glitch);
         if (start) begin
            op  = 2'b00;
            amt = 3'd1;
            din = ~d;
         end
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [2:0] a,
                               input logic [7:0] ed, input logic ec,
                               input int cycles, input int busy_cnt, input bit seen);
      int exp_cyc;
      exp_cyc = (a == 3'd0) ? 1 : int'(a) + 1;
      check({tag, " done_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"},   32'(cycles), 32'(exp_cyc));
      check({tag, " busy_cnt"},  32'(busy_cnt), 32'(a));
      check({tag, " dout"},      32'(dout), 32'(ed));
      check({tag, " carry"},     32'(carry), 32'(ec));
      $display("txn %s amt=%0d dout=%02h carry=%0b cycles=%0d busy=%0d",
               tag, a, dout, carry, cycles, busy_cnt);
   endtask

   initial begin
      int  cyc;
      int  bcnt;
      bit  seen;
      int  done_cnt;

      vecs[0] = '{2'b00, 3'd1, 8'h81, 8'h02, 1'b1, 0};   // SLL
      vecs[1] = '{2'b10, 3'd3, 8'h80, 8'hF0, 1'b0, 0};   // SRA sign fill
`ifdef SHIFT_ROTATE_EN
      vecs[2] = '{2'b11, 3'd4, 8'h81, 8'h18, 1'b0, 0};   // ROL
      vecs[3] = '{2'b11, 3'd1, 8'h80, 8'h01, 1'b1, 0};   // ROL wrap
`else
      vecs[2] = '{2'b11, 3'd4, 8'h81, 8'h10, 1'b0, 0};   // op 11 as SLL
      vecs[3] = '{2'b11, 3'd1, 8'h80, 8'h00, 1'b1, 0};
`endif
      vecs[4] = '{2'b01, 3'd7, 8'hFF, 8'h01, 1'b1, 3};   // SRL max, ignored start
      vecs[5] = '{2'b01, 3'd7, 8'h80, 8'h01, 1'b0, 0};
      vecs[6] = '{2'b10, 3'd2, 8'h7F, 8'h1F, 1'b1, 0};   // SRA positive
      vecs[7] = '{2'b00, 3'd7, 8'h01, 8'h80, 1'b0, 0};
      vecs[8] = '{2'b10, 3'd0, 8'hC3, 8'hC3, 1'b0, 0};   // amt 0

      rst   = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      amt   = 3'd0;
      din   = 8'h00;
      repeat (3) @(negedge clk);

      check("reset dout",  32'(dout),  32'h00);
      check("reset carry", 32'(carry), 32'd0);
      check("reset busy",  32'(busy),  32'd0);
      check("reset done",  32'(done),  32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         launch(vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].glitch, cyc, bcnt, seen);
         check_result($sformatf("vec%0d", i), vecs[i].amt, vecs[i].exp_dout,
                      vecs[i].exp_carry, cyc, bcnt, seen);
         @(negedge clk);
         check($sformatf("vec%0d done_pulse_end", i), 32'(done), 32'd0);
         check($sformatf("vec%0d idle_busy", i), 32'(busy), 32'd0);
         check($sformatf("vec%0d hold_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      end

      // amt 0 followed by a back-to-back start issued in DONE.
      launch(2'b00, 3'd0, 8'h5A, 0, cyc, bcnt, seen);
      check_result("amt0", 3'd0, 8'h5A, 1'b0, cyc, bcnt, seen);
      launch(2'b00, 3'd2, 8'h01, 0, cyc, bcnt, seen);
      check_result("b2b", 3'd2, 8'h04, 1'b0, cyc, bcnt, seen);
      @(negedge clk);
      check("b2b done_pulse_end", 32'(done), 32'd0);

      // Reset during SHIFT aborts the operation with no done pulse.
      start = 1'b1;
      op    = 2'b00;
      amt   = 3'd5;
      din   = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      check("abort busy_before", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      check("abort partial_dout", 32'(dout), 32'hFC);
      rst = 1'b0;
      @(negedge clk);
      check("abort dout",  32'(dout),  32'h00);
      check("abort carry", 32'(carry), 32'd0);
      check("abort busy",  32'(busy),  32'd0);
      check("abort done",  32'(done),  32'd0);
      rst = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      check("abort no_done", 32'(done_cnt), 32'd0);
      $display("txn abort dout=%02h busy=%0b done=%0b", dout, busy, done);

      // Recovery after the abort.
      launch(2'b00, 3'd1, 8'h03, 0, cyc, bcnt, seen);
      check_result("recover", 3'd1, 8'h06, 1'b0, cyc, bcnt, seen);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
